// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Input conditioning for raw board switch/key pins. Each channel is brought
//   into the clk domain through a two-flop synchroniser. It is then debounced:
//   a new value is accepted only after it has held steady for DB_CYCLES
//   consecutive cycles. The accepted value is presented as a clean level. Each
//   accepted transition also produces a one-cycle rise or fall pulse.
//
// Ports
//   clk    in   1      system clock
//   reset  in   1      synchronous, active-high reset
//   raw    in   WIDTH  asynchronous raw pin inputs
//   level  out  WIDTH  debounced, synchronised level
//   rise   out  WIDTH  one-cycle pulse on an accepted 0->1 transition
//   fall   out  WIDTH  one-cycle pulse on an accepted 1->0 transition
//
// Parameters
//   WIDTH      number of independent channels
//   DB_CYCLES  consecutive stable cycles needed to accept a change (>= 1)
//   CNT_W      debounce counter width, DB_CYCLES <= 2**CNT_W - 1
//   INIT       per-channel idle/reset level (1 for active-low keys)

module switch_debouncer #(
  parameter int                 WIDTH     = 4,
  parameter int                 DB_CYCLES = 500000,
  parameter int                 CNT_W     = 20,
  parameter logic [WIDTH-1:0]   INIT      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Counter value at which the pending change is accepted on the next edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  // Two-flop synchroniser. It loads the idle level on reset, so a pin
  // already at its idle level never starts a spurious count after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= INIT;
      sync2_reg <= INIT;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             rise_reg;
      logic             fall_reg;
      logic             s;

      assign s = sync2_reg[gi];

      // cnt counts consecutive cycles where the synchronised input disagrees
      // with the accepted level. Any agreeing cycle discards the run. The
      // counter is cleared on acceptance, so it never exceeds CNT_LAST and
      // cannot wrap.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          level_reg <= INIT[gi];
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (s == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            // Pulse is registered on the same edge as the level, so it is
            // high exactly in the first cycle the new level is visible.
            level_reg <= s;
            cnt_reg   <= '0;
            rise_reg  <= s;
            fall_reg  <= ~s;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
      end

      assign level[gi] = level_reg;
      assign rise[gi]  = rise_reg;
      assign fall[gi]  = fall_reg;
    end
  endgenerate

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with WIDTH=4, DB_CYCLES=4, INIT=4'b1000.
// Edge numbering: raw is changed just after edge 0. Outputs are sampled 1 ns
// after each later edge k. With DB_CYCLES=4 an accepted change appears after
// edge 6 (two synchroniser edges, three counting edges, one accept edge).

module tb_switch_debouncer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  int errors = 0;
  int checks = 0;

  switch_debouncer #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (4),
    .CNT_W     (20),
    .INIT      (4'b1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw   (raw),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles with raw at the idle level. Returns just after the
  // last reset edge, which the following test treats as edge 0.
  task automatic do_reset();
    reset = 1'b1;
    raw   = 4'b1000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    raw   = 4'b1000;

    // 1. Reset state, then idle with raw held for 20 cycles.
    do_reset();
    check("t1_level_rst", level, 4'b1000);
    check("t1_rise_rst",  rise,  4'b0000);
    check("t1_fall_rst",  fall,  4'b0000);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t1_level_k%0d", k), level, 4'b1000);
      check($sformatf("t1_pulse_k%0d", k), rise | fall, 4'b0000);
    end
    $display("t1 reset/idle done: level=%b", level);

    // 2. Clean press on channel 0.
    do_reset();
    raw = 4'b1001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("t2_level_k%0d", k), level, (k >= 6) ? 4'b1001 : 4'b1000);
      check($sformatf("t2_rise_k%0d", k),  rise,  (k == 6) ? 4'b0001 : 4'b0000);
      check($sformatf("t2_fall_k%0d", k),  fall,  4'b0000);
    end
    $display("t2 clean press done: level=%b", level);

    // 3. Bounce on channel 1: 2-cycle highs at edges 0 and 4, final rise at edge 8.
    do_reset();
    raw = 4'b1010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t3_level_k%0d", k), level, (k >= 14) ? 4'b1010 : 4'b1000);
      check($sformatf("t3_rise_k%0d", k),  rise,  (k == 14) ? 4'b0010 : 4'b0000);
      check($sformatf("t3_fall_k%0d", k),  fall,  4'b0000);
      case (k)
        2, 6:    raw = 4'b1000;
        4, 8:    raw = 4'b1010;
        default: ;
      endcase
    end
    $display("t3 bounce done: level=%b", level);

    // 4. Active-low key on channel 3: pressed at edge 0, released at edge 10.
    do_reset();
    raw = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t4_level_k%0d", k), level,
            (k >= 6 && k < 16) ? 4'b0000 : 4'b1000);
      check($sformatf("t4_fall_k%0d", k), fall, (k == 6)  ? 4'b1000 : 4'b0000);
      check($sformatf("t4_rise_k%0d", k), rise, (k == 16) ? 4'b1000 : 4'b0000);
      if (k == 10) raw = 4'b1000;
    end
    $display("t4 active-low key done: level=%b", level);

    // 5. Simultaneous change on channels 0..2.
    do_reset();
    raw = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t5_level_k%0d", k), level, (k >= 6) ? 4'b1111 : 4'b1000);
      check($sformatf("t5_rise_k%0d", k),  rise,  (k == 6) ? 4'b0111 : 4'b0000);
      check($sformatf("t5_fall_k%0d", k),  fall,  4'b0000);
    end
    $display("t5 simultaneous done: level=%b", level);

    // 6. Reset one edge before channel 2 would be accepted.
    do_reset();
    raw = 4'b1100;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("t6_pre_level_k%0d", k), level, 4'b1000);
      check($sformatf("t6_pre_rise_k%0d", k),  rise,  4'b0000);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_level_after_rst", level, 4'b1000);
    check("t6_rise_after_rst",  rise,  4'b0000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t6_level_k%0d", k), level, (k >= 6) ? 4'b1100 : 4'b1000);
      check($sformatf("t6_rise_k%0d", k),  rise,  (k == 6) ? 4'b0100 : 4'b0000);
      check($sformatf("t6_fall_k%0d", k),  fall,  4'b0000);
    end
    $display("t6 reset mid-count done: level=%b", level);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
